ram_dp_clr: RTL and testbench

//  Parametrised dual-port synchronous RAM for CPU/video shared memory: port A is

---
 rtl/ram_pkg.sv | 23 ++
 rtl/ram_dp_core.sv | 42 ++++
 rtl/ram_dp_clr.sv | 184 ++++++++++++++++++
 tb/tb_ram_dp_clr.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port RAM with clear engine.
// Byte-enable to bit-mask expansion lives here so every user expands lanes the same way.
package ram_pkg;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

  // Widest data bus supported by be_mask (bytes).
  localparam int unsigned MaxBytes = 16;

  // Expands one enable bit per byte into a full bit mask; callers truncate to their width.
  function automatic logic [MaxBytes*8-1:0] be_mask(input logic [MaxBytes-1:0] be);
    logic [MaxBytes*8-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MaxBytes; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/ram_dp_core.sv
// Bare RAM array: one masked write port and two synchronous read ports with old-data
// semantics. No reset anywhere so synthesis can map it onto block RAM.
module ram_dp_core #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] wmask_i,
  input  logic          re_a_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic          re_b_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] rdata_a_q;
  logic [DW-1:0] rdata_b_q;

  // Reads sample the array before this edge's write lands (read-old-data).
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
    end
    if (re_a_i) begin
      rdata_a_q <= mem_q[raddr_a_i];
    end
    if (re_b_i) begin
      rdata_b_q <= mem_q[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/ram_dp_clr.sv
// Dual-port RAM (A: read/write with byte enables, B: read-only) wrapped with a clear engine
// that zero-fills the array after reset or on request, plus optional B read-during-write bypass.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int unsigned    AW       = 10,
  parameter int unsigned    DW       = 8,
  parameter int unsigned    OUT_REG  = 0,
  parameter int unsigned    RDW_MODE = 0,
  parameter logic [DW-1:0]  CLR_VAL  = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_din,
  input  logic [DW/8-1:0] a_be,
  input  logic            a_cs_n,
  input  logic            a_we_n,
  output logic [DW-1:0]   a_dout,
  input  logic [AW-1:0]   b_addr,
  input  logic            b_cs_n,
  output logic [DW-1:0]   b_dout,
  input  logic            clr_req,
  output logic            busy
);

  clr_state_t    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          busy_int;

  logic          a_wr, a_rd, b_rd, byp_hit;
  logic [DW-1:0] a_mask;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_wmask;
  logic [DW-1:0] core_a, core_b;

  logic          a_vld_q, b_vld_q;
  logic          byp_q;
  logic [DW-1:0] byp_mask_q, byp_data_q;
  logic [DW-1:0] a_raw, b_raw;

  // ---------------------------------------------------------------------------
  // Clear FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLR_RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d   = CLR_RUN;
          clr_cnt_d = '0;
        end
      end
      CLR_RUN: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == '1) begin
          state_d = CLR_IDLE;
        end
      end
      default: begin
        state_d   = CLR_RUN;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    busy_int = (state_q == CLR_RUN);
  end

  assign busy = busy_int;

  // ---------------------------------------------------------------------------
  // Access decode and write mux (clear engine owns the write port while busy)
  // ---------------------------------------------------------------------------
  always_comb begin
    a_wr    = ~a_cs_n & ~a_we_n & ~busy_int;
    a_rd    = ~a_cs_n &  a_we_n & ~busy_int;
    b_rd    = ~b_cs_n & ~busy_int;
    a_mask  = DW'(be_mask(MaxBytes'(a_be)));
    byp_hit = (RDW_MODE != 0) && a_wr && b_rd && (a_addr == b_addr);
  end

  always_comb begin
    if (busy_int) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = CLR_VAL;
      mem_wmask = '1;
    end else begin
      mem_we    = a_wr;
      mem_waddr = a_addr;
      mem_wdata = a_din;
      mem_wmask = a_mask;
    end
  end

  ram_dp_core #(
    .AW (AW),
    .DW (DW)
  ) u_core (
    .clk_i     (clk),
    .we_i      (mem_we),
    .waddr_i   (mem_waddr),
    .wdata_i   (mem_wdata),
    .wmask_i   (mem_wmask),
    .re_a_i    (a_rd),
    .raddr_a_i (a_addr),
    .rdata_a_o (core_a),
    .re_b_i    (b_rd),
    .raddr_b_i (b_addr),
    .rdata_b_o (core_b)
  );

  // ---------------------------------------------------------------------------
  // Read-side state: valid flags give reset-to-zero outputs over an unreset array,
  // bypass registers hold the colliding write so B can see merged data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_vld_q    <= 1'b0;
      b_vld_q    <= 1'b0;
      byp_q      <= 1'b0;
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else begin
      if (a_rd) begin
        a_vld_q <= 1'b1;
      end
      if (b_rd) begin
        b_vld_q    <= 1'b1;
        byp_q      <= byp_hit;
        byp_mask_q <= a_mask;
        byp_data_q <= a_din;
      end
    end
  end

  always_comb begin
    a_raw = a_vld_q ? core_a : '0;
    b_raw = '0;
    if (b_vld_q) begin
      b_raw = byp_q ? ((core_b & ~byp_mask_q) | (byp_data_q & byp_mask_q)) : core_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional output stage
  // ---------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_oreg
    logic [DW-1:0] a_dout_q, b_dout_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_dout_q <= '0;
        b_dout_q <= '0;
      end else begin
        a_dout_q <= a_raw;
        b_dout_q <= b_raw;
      end
    end

    assign a_dout = a_dout_q;
    assign b_dout = b_dout_q;
  end else begin : g_no_oreg
    assign a_dout = a_raw;
    assign b_dout = b_raw;
  end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench for ram_dp_clr: two instances (latency 1 / old-data, latency 2 / merged
// data) share one stimulus stream; a reference memory predicts every read.
module tb_ram_dp_clr;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;
  localparam int unsigned N  = 2 ** AW;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic [AW-1:0]   a_addr = '0;
  logic [DW-1:0]   a_din  = '0;
  logic [DW/8-1:0] a_be   = '0;
  logic            a_cs_n = 1'b1;
  logic            a_we_n = 1'b1;
  logic [AW-1:0]   b_addr = '0;
  logic            b_cs_n = 1'b1;
  logic            clr_req = 1'b0;

  logic [DW-1:0]   a_dout0, b_dout0, a_dout1, b_dout1;
  logic            busy0, busy1;

  always #5 clk = ~clk;

  ram_dp_clr #(.AW(AW), .DW(DW), .OUT_REG(0), .RDW_MODE(0)) u_dut0 (
    .clk (clk), .reset (reset),
    .a_addr (a_addr), .a_din (a_din), .a_be (a_be), .a_cs_n (a_cs_n), .a_we_n (a_we_n),
    .a_dout (a_dout0), .b_addr (b_addr), .b_cs_n (b_cs_n), .b_dout (b_dout0),
    .clr_req (clr_req), .busy (busy0)
  );

  ram_dp_clr #(.AW(AW), .DW(DW), .OUT_REG(1), .RDW_MODE(1)) u_dut1 (
    .clk (clk), .reset (reset),
    .a_addr (a_addr), .a_din (a_din), .a_be (a_be), .a_cs_n (a_cs_n), .a_we_n (a_we_n),
    .a_dout (a_dout1), .b_addr (b_addr), .b_cs_n (b_cs_n), .b_dout (b_dout1),
    .clr_req (clr_req), .busy (busy1)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] val;
  } sb_t;

  // Stream index: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
  sb_t           sbq [4][$];
  logic [DW-1:0] exp_v [4] = '{default: '0};
  logic [DW-1:0] mem_m [N];
  logic          m_busy = 1'b1;
  int            m_cnt  = 0;
  int            cyc    = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    logic [DW-1:0] obs [4];
    obs[0] = a_dout0;
    obs[1] = b_dout0;
    obs[2] = a_dout1;
    obs[3] = b_dout1;
    for (int i = 0; i < 4; i++) begin
      while (sbq[i].size() > 0 && sbq[i][0].due <= cyc) begin
        exp_v[i] = sbq[i][0].val;
        void'(sbq[i].pop_front());
      end
      check($sformatf("dout%0d", i), 32'(obs[i]), 32'(exp_v[i]));
    end
    check("busy0", 32'(busy0), 32'(m_busy));
    check("busy1", 32'(busy1), 32'(m_busy));
  end

  task automatic push(input int idx, input int due, input logic [DW-1:0] val);
    sb_t e;
    e.due = due;
    e.val = val;
    sbq[idx].push_back(e);
  endtask

  // One clock of stimulus; starts and ends just after a falling edge.
  task automatic drive(input logic acs_n, input logic awe_n, input logic [AW-1:0] aaddr,
                       input logic [DW-1:0] adin, input logic [1:0] abe, input logic bcs_n,
                       input logic [AW-1:0] baddr, input logic creq);
    logic [DW-1:0] m, old, mrg;
    logic          awr, ard, brd;
    a_cs_n = acs_n; a_we_n = awe_n; a_addr = aaddr; a_din = adin; a_be = abe;
    b_cs_n = bcs_n; b_addr = baddr; clr_req = creq;
    awr = !acs_n && !awe_n && !m_busy;
    ard = !acs_n &&  awe_n && !m_busy;
    brd = !bcs_n && !m_busy;
    m   = {{8{abe[1]}}, {8{abe[0]}}};
    if (ard) begin
      push(0, cyc + 1, mem_m[aaddr]);
      push(2, cyc + 2, mem_m[aaddr]);
    end
    if (brd) begin
      old = mem_m[baddr];
      mrg = (awr && aaddr == baddr) ? ((old & ~m) | (adin & m)) : old;
      push(1, cyc + 1, old);
      push(3, cyc + 2, mrg);
    end
    if (awr) mem_m[aaddr] = (mem_m[aaddr] & ~m) | (adin & m);
    @(posedge clk);
    if (!reset) begin
      if (m_busy) begin
        mem_m[m_cnt] = '0;
        if (m_cnt == N - 1) m_busy = 1'b0;
        m_cnt++;
      end else if (creq) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, '0, '0, 2'b00, 1'b1, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [1:0] be);
    drive(1'b0, 1'b0, addr, d, be, 1'b1, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] aaddr, input logic [AW-1:0] baddr);
    drive(1'b0, 1'b1, aaddr, '0, 2'b00, 1'b0, baddr, 1'b0);
  endtask

  task automatic req_clear();
    drive(1'b1, 1'b1, '0, '0, 2'b00, 1'b1, '0, 1'b1);
  endtask

  // Counts falling-edge samples with busy high; bounded so a stuck engine cannot hang the run.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy0 && n < 4 * N) begin
      n++;
      idle();
    end
    check(tag, 32'(n), 32'(N));
  endtask

  task automatic apply_reset(input int hold);
    #2 reset = 1'b1;
    m_busy = 1'b1;
    m_cnt  = 0;
    for (int i = 0; i < 4; i++) begin
      sbq[i].delete();
      exp_v[i] = '0;
    end
    #1;
    check("rst_busy", 32'(busy0), 32'd1);
    check("rst_adout0", 32'(a_dout0), 32'd0);
    check("rst_bdout1", 32'(b_dout1), 32'd0);
    repeat (hold) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("por_adout", 32'(a_dout0), 32'd0);
    check("por_bdout", 32'(b_dout1), 32'd0);
    #2 reset = 1'b0;
    count_busy("clr_len_por");
    for (int i = 0; i < int'(N); i++) rd(AW'(i), AW'(N - 1 - i));
    idle(); idle();

    // Byte-lane write then B read.
    wr(5'h12, 16'h00A5, 2'b01);
    drive(1'b1, 1'b1, '0, '0, 2'b00, 1'b0, 5'h12, 1'b0);
    idle(); idle();
    check("b_a5_lat", 32'(b_dout1), 32'h00A5);

    // Read-during-write collision on B.
    wr(5'd3, 16'h1234, 2'b11);
    drive(1'b0, 1'b0, 5'd3, 16'hABCD, 2'b01, 1'b0, 5'd3, 1'b0);
    idle(); idle();
    check("rdw_old", 32'(b_dout0), 32'h1234);
    check("rdw_new", 32'(b_dout1), 32'h12CD);
    rd(5'd3, 5'd3);
    idle(); idle();

    // Mixed random traffic on a small address window so collisions happen.
    repeat (80) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
            DW'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 7)), 1'b0);
    end
    idle(); idle();

    // Requested clear drops writes and ignores a second request.
    wr(5'd1, 16'hBEEF, 2'b11);
    rd(5'd1, 5'd1);
    req_clear();
    begin
      int n;
      n = 0;
      while (busy0 && n < 4 * N) begin
        n++;
        if (n == 3) wr(5'd1, 16'h0055, 2'b11);
        else if (n == 10) req_clear();
        else rd(5'd1, 5'd2);
      end
      check("clr_len_req", 32'(n), 32'(N));
    end
    rd(5'd1, 5'd1);
    idle(); idle();
    check("clr_word1", 32'(a_dout1), 32'd0);

    // Outputs hold while the ports are idle or A is writing.
    wr(5'd7, 16'h0077, 2'b11);
    rd(5'd7, 5'd7);
    repeat (10) idle();
    check("hold_a", 32'(a_dout0), 32'h0077);
    check("hold_b", 32'(b_dout1), 32'h0077);
    wr(5'd9, 16'h1111, 2'b11);
    idle(); idle();
    check("hold_a_wr", 32'(a_dout1), 32'h0077);

    // Reset in the middle of a running clear restarts it from scratch.
    req_clear();
    repeat (5) idle();
    apply_reset(2);
    count_busy("clr_len_mid");
    for (int i = 0; i < int'(N); i++) rd(AW'(N - 1 - i), AW'(i));
    repeat (4) idle();
    for (int i = 0; i < 4; i++) check($sformatf("sb_drain%0d", i), 32'(sbq[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
